// File: rtl/tetris_pkg.sv
// Shared PS/2 keyboard constants, key indices and decoder/receiver state types.
// Also holds the (ext, code) -> key lookup.
package tetris_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_ROTATE = 8'h75;
   localparam logic [7:0] SC_DROP   = 8'h29;

   localparam int NUM_KEYS = 5;

   typedef enum logic [2:0] {
      KEY_LEFT   = 3'd0,
      KEY_RIGHT  = 3'd1,
      KEY_DOWN   = 3'd2,
      KEY_ROTATE = 3'd3,
      KEY_DROP   = 3'd4,
      KEY_NONE   = 3'd7
   } key_e;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   // Bit 0 is the E0 (extended) prefix flag, bit 1 the F0 (break) prefix flag.
   typedef enum logic [1:0] {
      DEC_BASE    = 2'b00,
      DEC_EXT     = 2'b01,
      DEC_BRK     = 2'b10,
      DEC_EXT_BRK = 2'b11
   } dec_state_e;

   function automatic key_e key_lookup(input logic ext, input logic [7:0] code);
      key_e k;
      k = KEY_NONE;
      if (ext) begin
         case (code)
            SC_LEFT:   k = KEY_LEFT;
            SC_RIGHT:  k = KEY_RIGHT;
            SC_DOWN:   k = KEY_DOWN;
            SC_ROTATE: k = KEY_ROTATE;
            default:   k = KEY_NONE;
         endcase
      end else if (code == SC_DROP) begin
         k = KEY_DROP;
      end
      return k;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte stream from the PS/2 receiver to the make/break decoder.
// All signals are single-cycle strobes with no ready: the decoder accepts every byte.
interface ps2_key_decoder_if;
   logic       byte_done;
   logic [7:0] byte_data;
   logic       start_err;
   logic       frame_bad;

   modport master (output byte_done, byte_data, start_err, frame_bad);
   modport slave  (input  byte_done, byte_data, start_err, frame_bad);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit deserializer,
// odd-parity/stop checking and an inactivity timeout that abandons partial frames.
module ps2_rx
   import tetris_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_key_decoder_if.master  rx
);

   localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       data_sync_q, data_sync_d;
   logic             clk_prev_q, clk_prev_d;
   rx_state_e        state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic fall, din, byte_done, start_err, frame_bad;

   assign fall = clk_prev_q & ~clk_sync_q[1];
   assign din  = data_sync_q[1];

   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      clk_prev_d  = clk_sync_q[1];
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      byte_done   = 1'b0;
      start_err   = 1'b0;
      frame_bad   = 1'b0;
      if (fall) begin
         // An edge always wins over a coincident timeout.
         cnt_d = '0;
         case (state_q)
            RX_IDLE: begin
               if (din) begin
                  start_err = 1'b1;
               end else begin
                  state_d   = RX_DATA;
                  bit_cnt_d = 3'd0;
                  par_d     = 1'b0;
               end
            end
            RX_DATA: begin
               shift_d   = {din, shift_q[7:1]};
               par_d     = par_q ^ din;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
            RX_PARITY: begin
               par_d   = par_q ^ din;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               state_d   = RX_IDLE;
               bit_cnt_d = 3'd0;
               if (din && par_q) byte_done = 1'b1;
               else              frame_bad = 1'b1;
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (state_q != RX_IDLE && cnt_q == CNT_MAX) begin
         state_d   = RX_IDLE;
         bit_cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         state_q     <= RX_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         par_q       <= 1'b0;
         cnt_q       <= CNT_MAX;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rx.byte_done = byte_done;
   assign rx.byte_data = shift_q;
   assign rx.start_err = start_err;
   assign rx.frame_bad = frame_bad;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives scan codes and tracks E0/F0 prefixes to
// maintain held-key levels for the game's five controls.
module ps2_key_decoder
   import tetris_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       raw_left,
   output logic       raw_right,
   output logic       raw_down,
   output logic       raw_rotate,
   output logic       raw_drop,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   ps2_key_decoder_if rx_if ();

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx       (rx_if)
   );

   dec_state_e          dec_q, dec_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [7:0]          scan_code_q, scan_code_d;
   logic                scan_valid_q, scan_valid_d;
   logic                frame_err_q, frame_err_d;
   logic                ext, brk;
   key_e                key;

   assign ext = dec_q[0];
   assign brk = dec_q[1];

   always_comb begin
      dec_d        = dec_q;
      held_d       = held_q;
      scan_code_d  = scan_code_q;
      scan_valid_d = 1'b0;
      frame_err_d  = rx_if.start_err | rx_if.frame_bad;
      key          = KEY_NONE;
      if (rx_if.byte_done) begin
         scan_valid_d = 1'b1;
         scan_code_d  = rx_if.byte_data;
         if (rx_if.byte_data == SC_EXT) begin
            dec_d = dec_state_e'({brk, 1'b1});
         end else if (rx_if.byte_data == SC_BRK) begin
            dec_d = dec_state_e'({1'b1, ext});
         end else begin
            // Held level follows make/break; repeats of a make simply rewrite 1.
            key = key_lookup(ext, rx_if.byte_data);
            for (int i = 0; i < NUM_KEYS; i++) begin
               if (key == key_e'(3'(i))) held_d[i] = ~brk;
            end
            dec_d = DEC_BASE;
         end
      end else if (rx_if.frame_bad) begin
         dec_d = DEC_BASE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q        <= DEC_BASE;
         held_q       <= '0;
         scan_code_q  <= 8'h00;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         dec_q        <= dec_d;
         held_q       <= held_d;
         scan_code_q  <= scan_code_d;
         scan_valid_q <= scan_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign raw_left   = held_q[KEY_LEFT];
   assign raw_right  = held_q[KEY_RIGHT];
   assign raw_down   = held_q[KEY_DOWN];
   assign raw_rotate = held_q[KEY_ROTATE];
   assign raw_drop   = held_q[KEY_DROP];
   assign scan_code  = scan_code_q;
   assign scan_valid = scan_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed
// expected raw key levels, scan codes and pulse counts.
module tb_ps2_key_decoder;

   localparam int TO   = 500;
   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       raw_left, raw_right, raw_down, raw_rotate, raw_drop;
   logic [7:0] scan_code;
   logic       scan_valid, frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int v0, e0;

   logic       smp_valid, smp_err;
   logic [7:0] smp_code;
   logic [4:0] smp_raw;

   always #5 clk = ~clk;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .raw_left   (raw_left),
      .raw_right  (raw_right),
      .raw_down   (raw_down),
      .raw_rotate (raw_rotate),
      .raw_drop   (raw_drop),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .frame_err  (frame_err)
   );

   always @(negedge clk) begin
      if (scan_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1)  n_ferr++;
   end

   function automatic logic [4:0] raw_vec();
      return {raw_drop, raw_rotate, raw_down, raw_right, raw_left};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One PS/2 bit; outputs are sampled 3 clk after the falling edge is driven
   // (2 synchronizer flops, then the registered result of the edge cycle).
   task automatic pulse_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (HALF/2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      smp_valid = scan_valid;
      smp_err   = frame_err;
      smp_code  = scan_code;
      smp_raw   = raw_vec();
      repeat (HALF-3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                             input bit bad_stop = 1'b0, input int nbits = 11);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) pulse_bit(f[i]);
   endtask

   task automatic send_ext(input logic [7:0] b);
      send_frame(8'hE0);
      send_frame(b);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_raw",   32'(raw_vec()),  32'h0);
      check("rst_code",  32'(scan_code),  32'h0);
      check("rst_valid", 32'(scan_valid), 32'h0);
      check("rst_err",   32'(frame_err),  32'h0);

      // Extended left press, then release.
      send_frame(8'hE0);
      check("e0_valid", 32'(smp_valid), 32'h1);
      check("e0_raw",   32'(smp_raw),   32'h0);
      send_frame(8'h6B);
      check("left_valid", 32'(smp_valid), 32'h1);
      check("left_code",  32'(smp_code),  32'h6B);
      check("left_press", 32'(smp_raw),   32'h01);
      v0 = n_valid;
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
      check("left_release", 32'(smp_raw), 32'h00);
      check("release_pulses", 32'(n_valid - v0), 32'd3);

      // Bad parity on Space is dropped, then a good Space presses drop.
      v0 = n_valid; e0 = n_ferr;
      send_frame(8'h29, 1'b1);
      check("par_err",     32'(smp_err),       32'h1);
      check("par_nvalid",  32'(n_valid - v0),  32'd0);
      check("par_nerr",    32'(n_ferr - e0),   32'd1);
      check("par_drop",    32'(smp_raw),       32'h00);
      send_frame(8'h29);
      check("drop_press",  32'(smp_raw), 32'h10);
      send_frame(8'hF0); send_frame(8'h29);
      check("drop_release", 32'(smp_raw), 32'h00);

      // Partial frame abandoned by the timeout, no error, then a clean 75.
      e0 = n_ferr;
      send_frame(8'h75, 1'b0, 1'b0, 7);
      repeat (600) @(negedge clk);
      send_frame(8'h75);
      check("to_nerr",  32'(n_ferr - e0), 32'd0);
      check("to_valid", 32'(smp_valid),   32'h1);
      check("to_code",  32'(smp_code),    32'h75);
      check("to_raw",   32'(smp_raw),     32'h00);

      // Rotate and drop together, typematic rotate, release rotate only.
      send_ext(8'h75);
      check("rot_press", 32'(smp_raw), 32'h08);
      send_frame(8'h29);
      check("rot_drop", 32'(smp_raw), 32'h18);
      for (int r = 0; r < 3; r++) begin
         send_ext(8'h75);
         check("rot_repeat", 32'(smp_raw), 32'h18);
      end
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      check("rot_release", 32'(smp_raw), 32'h10);

      // Start bit sampled as 1.
      e0 = n_ferr;
      pulse_bit(1'b1);
      check("start_err",  32'(smp_err),     32'h1);
      check("start_nerr", 32'(n_ferr - e0), 32'd1);
      send_frame(8'hF0); send_frame(8'h29);
      check("after_start", 32'(smp_raw), 32'h00);

      // Bad stop bit clears the pending E0, so the next 6B is keypad (unmapped).
      send_frame(8'hE0);
      send_frame(8'h6B, 1'b0, 1'b1);
      check("stop_err",    32'(smp_err),   32'h1);
      check("stop_nvalid", 32'(smp_valid), 32'h0);
      send_frame(8'h6B);
      check("kp_valid", 32'(smp_valid), 32'h1);
      check("kp_raw",   32'(smp_raw),   32'h00);
      send_ext(8'h29);
      check("e0_29_raw", 32'(smp_raw), 32'h00);

      // Bad parity clears a pending F0: following Space is a make.
      send_frame(8'hF0);
      send_frame(8'h72, 1'b1);
      send_frame(8'h29);
      check("brk_cleared", 32'(smp_raw), 32'h10);
      send_frame(8'hF0); send_frame(8'h29);
      send_ext(8'h72);
      check("down_press", 32'(smp_raw), 32'h04);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h72);

      // Reset in the middle of E0 74.
      send_ext(8'h74);
      check("right_press", 32'(smp_raw), 32'h02);
      send_frame(8'hE0);
      send_frame(8'h74, 1'b0, 1'b0, 5);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("mid_rst_raw",   32'(raw_vec()),  32'h0);
      check("mid_rst_code",  32'(scan_code),  32'h0);
      check("mid_rst_valid", 32'(scan_valid), 32'h0);
      check("mid_rst_err",   32'(frame_err),  32'h0);
      send_ext(8'h74);
      check("right_again", 32'(smp_raw),  32'h02);
      check("right_code",  32'(smp_code), 32'h74);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
